// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter: arbitrates icache/dcache requests onto the single-outstanding
// AXI bridge port, waits for the bridge to finish, then returns a one-cycle
// response pulse with the captured read data to the cache that owns the request.
// Optional feature macro: CACHE_ARB_ROUND_ROBIN_EN (round-robin when defined,
// fixed dcache priority otherwise).
module cache_axi_arbiter #(
  parameter int BLOCK_WIDTH = 128,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ic_valid,
  input  logic                   dc_valid,
  output logic                   ic_ready,
  output logic                   dc_ready,
  input  logic                   ic_we,
  input  logic                   dc_we,
  input  logic                   ic_cached,
  input  logic                   dc_cached,
  input  logic [ADDR_WIDTH-1:0]  ic_addr,
  input  logic [ADDR_WIDTH-1:0]  dc_addr,
  input  logic [BLOCK_WIDTH-1:0] ic_wblock,
  input  logic [BLOCK_WIDTH-1:0] dc_wblock,
  input  logic [31:0]            ic_wword,
  input  logic [31:0]            dc_wword,
  input  logic [3:0]             ic_wstrb,
  input  logic [3:0]             dc_wstrb,
  output logic                   ic_resp,
  output logic                   dc_resp,
  output logic [BLOCK_WIDTH-1:0] resp_rblock,
  output logic [31:0]            resp_rword,
  output logic                   down_valid,
  input  logic                   down_ready,
  output logic                   down_we,
  output logic                   down_cached,
  output logic [ADDR_WIDTH-1:0]  down_addr,
  output logic [BLOCK_WIDTH-1:0] down_wblock,
  output logic [31:0]            down_wword,
  output logic [3:0]             down_wstrb,
  input  logic                   down_finish,
  input  logic [BLOCK_WIDTH-1:0] down_rblock,
  input  logic [31:0]            down_rword
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]             state_q, state_d;
  logic                   owner_q;      // 1 = dcache owns the transaction
  logic                   grant_dc;     // dcache wins if a request is taken now
  logic                   accept;
  logic                   we_q, cached_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [BLOCK_WIDTH-1:0] wblock_q;
  logic [31:0]            wword_q;
  logic [3:0]             wstrb_q;
  logic [BLOCK_WIDTH-1:0] rblock_q;
  logic [31:0]            rword_q;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  logic favour_dc_q;

  // Simultaneous requests go to the favoured side; a lone requester always wins.
  always_comb grant_dc = dc_valid && (!ic_valid || favour_dc_q);

  // After every grant, favour the requester that just lost its turn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      favour_dc_q <= 1'b1;
    end else if (accept) begin
      favour_dc_q <= ~grant_dc;
    end
  end
`else
  // Fixed priority: the dcache wins whenever it is requesting.
  always_comb grant_dc = dc_valid;
`endif

  assign accept = (state_q == S_IDLE) && (ic_valid || dc_valid);

  // Ready is only offered in IDLE; held low while reset is asserted.
  always_comb begin
    ic_ready = accept && !grant_dc && !rst;
    dc_ready = accept && grant_dc && !rst;
  end

  // Sequencer: one outstanding transaction, IDLE -> ISSUE -> WAIT -> RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)      state_d = S_ISSUE;
      S_ISSUE: if (down_ready)  state_d = S_WAIT;
      S_WAIT:  if (down_finish) state_d = S_RESP;
      default:                  state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the winner's request fields and owner when the request is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      cached_q <= 1'b0;
      addr_q   <= '0;
      wblock_q <= '0;
      wword_q  <= '0;
      wstrb_q  <= '0;
    end else if (accept) begin
      owner_q  <= grant_dc;
      we_q     <= grant_dc ? dc_we     : ic_we;
      cached_q <= grant_dc ? dc_cached : ic_cached;
      addr_q   <= grant_dc ? dc_addr   : ic_addr;
      wblock_q <= grant_dc ? dc_wblock : ic_wblock;
      wword_q  <= grant_dc ? dc_wword  : ic_wword;
      wstrb_q  <= grant_dc ? dc_wstrb  : ic_wstrb;
    end
  end

  // Capture bridge read data on completion; held until the next completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rblock_q <= '0;
      rword_q  <= '0;
    end else if (state_q == S_WAIT && down_finish) begin
      rblock_q <= down_rblock;
      rword_q  <= down_rword;
    end
  end

  // Output mapping: bridge request in ISSUE, owner response pulse in RESP.
  always_comb begin
    down_valid  = (state_q == S_ISSUE);
    down_we     = we_q;
    down_cached = cached_q;
    down_addr   = addr_q;
    down_wblock = wblock_q;
    down_wword  = wword_q;
    down_wstrb  = wstrb_q;
    ic_resp     = (state_q == S_RESP) && !owner_q;
    dc_resp     = (state_q == S_RESP) && owner_q;
    resp_rblock = rblock_q;
    resp_rword  = rword_q;
  end

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// tb_cache_axi_arbiter: directed + randomized transactions against a small
// arbitration/latency reference model; bridge behaviour scripted per transaction.
module tb_cache_axi_arbiter;
  localparam int BW = 128;
  localparam int AW = 32;

  logic          clk, rst;
  logic          ic_valid, dc_valid, ic_ready, dc_ready;
  logic          ic_we, dc_we, ic_cached, dc_cached;
  logic [AW-1:0] ic_addr, dc_addr;
  logic [BW-1:0] ic_wblock, dc_wblock;
  logic [31:0]   ic_wword, dc_wword;
  logic [3:0]    ic_wstrb, dc_wstrb;
  logic          ic_resp, dc_resp;
  logic [BW-1:0] resp_rblock;
  logic [31:0]   resp_rword;
  logic          down_valid, down_ready, down_we, down_cached;
  logic [AW-1:0] down_addr;
  logic [BW-1:0] down_wblock;
  logic [31:0]   down_wword;
  logic [3:0]    down_wstrb;
  logic          down_finish;
  logic [BW-1:0] down_rblock;
  logic [31:0]   down_rword;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state: who is waiting, and who wins a tie next.
  bit pend_ic, pend_dc, favour_dc;
  bit grant_log[$];
  int accept_log[$];

  cache_axi_arbiter #(.BLOCK_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .ic_valid(ic_valid), .dc_valid(dc_valid),
    .ic_ready(ic_ready), .dc_ready(dc_ready),
    .ic_we(ic_we), .dc_we(dc_we),
    .ic_cached(ic_cached), .dc_cached(dc_cached),
    .ic_addr(ic_addr), .dc_addr(dc_addr),
    .ic_wblock(ic_wblock), .dc_wblock(dc_wblock),
    .ic_wword(ic_wword), .dc_wword(dc_wword),
    .ic_wstrb(ic_wstrb), .dc_wstrb(dc_wstrb),
    .ic_resp(ic_resp), .dc_resp(dc_resp),
    .resp_rblock(resp_rblock), .resp_rword(resp_rword),
    .down_valid(down_valid), .down_ready(down_ready),
    .down_we(down_we), .down_cached(down_cached), .down_addr(down_addr),
    .down_wblock(down_wblock), .down_wword(down_wword), .down_wstrb(down_wstrb),
    .down_finish(down_finish), .down_rblock(down_rblock), .down_rword(down_rword)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [399:0] obs, input logic [399:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk(tag, {ic_ready, dc_ready, ic_resp, dc_resp, down_valid, down_we, down_cached,
              down_addr, down_wblock, down_wword, down_wstrb, resp_rblock, resp_rword}, '0);
  endtask

  function automatic logic [BW-1:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic rand_ic();
    ic_we = 1'($urandom_range(0, 1)); ic_cached = 1'($urandom_range(0, 1));
    ic_addr = $urandom; ic_wblock = rand_block(); ic_wword = $urandom; ic_wstrb = 4'($urandom);
  endtask

  task automatic rand_dc();
    dc_we = 1'($urandom_range(0, 1)); dc_cached = 1'($urandom_range(0, 1));
    dc_addr = $urandom; dc_wblock = rand_block(); dc_wword = $urandom; dc_wstrb = 4'($urandom);
  endtask

  // Arbitration rule: lone requester wins; ties resolved by the configured policy.
  function automatic bit model_pick_dc(bit p_ic, bit p_dc);
    if (p_ic && !p_dc) return 1'b0;
    if (p_dc && !p_ic) return 1'b1;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    return favour_dc;
`else
    return 1'b1;
`endif
  endfunction

  // One complete transaction starting in an IDLE cycle (entered at +1 or +2 after
  // the edge); returns in the following IDLE cycle. rdly = ISSUE cycles without
  // down_ready, fdly = WAIT cycles without down_finish.
  task automatic txn(input bit new_ic, input bit new_dc, input int rdly, input int fdly,
                     input bit ghost_finish, input bit late_ic,
                     input logic [BW-1:0] rb, input logic [31:0] rw);
    bit win_dc;
    bit exp_we;
    logic [197:0] exp_f;
    int acc;
    if (new_ic) begin ic_valid = 1'b1; pend_ic = 1'b1; end
    if (new_dc) begin dc_valid = 1'b1; pend_dc = 1'b1; end
    #1;
    win_dc = model_pick_dc(pend_ic, pend_dc);
    chk("ic_ready_accept", ic_ready, !win_dc);
    chk("dc_ready_accept", dc_ready, win_dc);
    grant_log.push_back(dc_ready);
    exp_we = win_dc ? dc_we : ic_we;
    exp_f = win_dc ? {dc_we, dc_cached, dc_addr, dc_wblock, dc_wword, dc_wstrb}
                   : {ic_we, ic_cached, ic_addr, ic_wblock, ic_wword, ic_wstrb};
    acc = cyc;
    accept_log.push_back(acc);
    favour_dc = !win_dc;
    tick();
    // Drop the granted request and scramble its inputs: the bridge must see latched copies.
    if (win_dc) begin
      dc_valid = 1'b0; pend_dc = 1'b0; dc_addr = ~dc_addr; dc_wblock = ~dc_wblock; dc_wword = ~dc_wword;
    end else begin
      ic_valid = 1'b0; pend_ic = 1'b0; ic_addr = ~ic_addr; ic_wblock = ~ic_wblock; ic_wword = ~ic_wword;
    end
    for (int i = 0; i <= rdly; i++) begin
      down_ready  = (i == rdly);
      down_finish = ghost_finish && (i == 0);
      if (late_ic && i == 0 && !pend_ic) begin
        rand_ic(); ic_valid = 1'b1; pend_ic = 1'b1;
      end
      #1;
      chk("down_valid_issue", down_valid, 1'b1);
      chk("down_fields", {down_we, down_cached, down_addr, down_wblock, down_wword, down_wstrb}, exp_f);
      chk("ready_issue", {ic_ready, dc_ready}, 2'b00);
      chk("resp_issue", {ic_resp, dc_resp}, 2'b00);
      tick();
    end
    down_ready = 1'b0;
    down_finish = 1'b0;
    for (int i = 0; i <= fdly; i++) begin
      if (i == fdly) begin down_finish = 1'b1; down_rblock = rb; down_rword = rw; end
      #1;
      chk("down_valid_wait", down_valid, 1'b0);
      chk("ready_wait", {ic_ready, dc_ready}, 2'b00);
      chk("resp_wait", {ic_resp, dc_resp}, 2'b00);
      tick();
    end
    down_finish = 1'b0; down_rblock = ~rb; down_rword = ~rw;
    #1;
    chk("resp_owner", {ic_resp, dc_resp}, {!win_dc, win_dc});
    chk("resp_latency", 32'(cyc - acc), 32'(3 + rdly + fdly));
    chk("ready_resp", {ic_ready, dc_ready}, 2'b00);
    if (!exp_we) chk("resp_data", {resp_rblock, resp_rword}, {rb, rw});
    tick();
    #1;
    chk("resp_idle", {ic_resp, dc_resp}, 2'b00);
    if (!exp_we) chk("resp_hold", {resp_rblock, resp_rword}, {rb, rw});
  endtask

  initial begin
    bit exp_order[4];
    bit n_ic, n_dc;
    rst = 1'b1;
    ic_valid = 0; dc_valid = 0; ic_we = 0; dc_we = 0; ic_cached = 0; dc_cached = 0;
    ic_addr = 0; dc_addr = 0; ic_wblock = 0; dc_wblock = 0; ic_wword = 0; dc_wword = 0;
    ic_wstrb = 0; dc_wstrb = 0; down_ready = 0; down_finish = 0; down_rblock = 0; down_rword = 0;
    pend_ic = 0; pend_dc = 0; favour_dc = 1'b1;
    tick();
    tick();
    check_zero("reset_state");
    rst = 1'b0;

    // Simultaneous requests, three rounds, then drain whoever is left.
    grant_log.delete();
    for (int k = 0; k < 3; k++) begin
      n_ic = !pend_ic; n_dc = !pend_dc;
      if (n_ic) rand_ic();
      if (n_dc) rand_dc();
      txn(n_ic, n_dc, 0, 0, 1'b0, 1'b0, rand_block(), $urandom);
    end
    if (pend_ic || pend_dc) txn(1'b0, 1'b0, 0, 1, 1'b0, 1'b0, rand_block(), $urandom);
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b0};
`endif
    chk("grant_count", 32'(grant_log.size()), 32'd4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++) chk("grant_order", grant_log[k], exp_order[k]);

    // Single icache cached read; finish 5 cycles after the bridge accepts.
    ic_we = 1'b0; ic_cached = 1'b1; ic_addr = 32'h1C00_0000; ic_wblock = rand_block();
    ic_wword = $urandom; ic_wstrb = 4'h0;
    txn(1'b1, 1'b0, 0, 4, 1'b0, 1'b0, 128'h0123456789ABCDEF0123456789ABCDEF, 32'h89ABCDEF);

    // Dcache uncached word write.
    dc_we = 1'b1; dc_cached = 1'b0; dc_addr = 32'hBFAF_8000; dc_wblock = rand_block();
    dc_wword = 32'hDEAD_BEEF; dc_wstrb = 4'hF;
    txn(1'b0, 1'b1, 0, 2, 1'b0, 1'b0, rand_block(), $urandom);

    // Bridge backpressure with a stray finish in ISSUE and a late icache request.
    rand_dc(); dc_we = 1'b0;
    txn(1'b0, 1'b1, 10, 1, 1'b1, 1'b1, rand_block(), $urandom);
    txn(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, rand_block(), $urandom);

    // Reset while waiting for the bridge.
    rand_ic(); ic_we = 1'b0; ic_valid = 1'b1; pend_ic = 1'b1;
    #1;
    chk("rst_pre_ready", ic_ready, !model_pick_dc(pend_ic, pend_dc));
    tick();
    ic_valid = 1'b0; pend_ic = 1'b0; down_ready = 1'b1;
    #1;
    chk("rst_pre_issue", down_valid, 1'b1);
    tick();
    down_ready = 1'b0;
    #1;
    chk("rst_pre_wait", down_valid, 1'b0);
    tick();
    rand_ic(); ic_valid = 1'b1; pend_ic = 1'b1; rst = 1'b1;
    #1;
    check_zero("rst_in_wait");
    tick();
    down_finish = 1'b1; down_rblock = rand_block(); down_rword = $urandom;
    #1;
    check_zero("rst_hold");
    tick();
    down_finish = 1'b0; rst = 1'b0; favour_dc = 1'b1;
    txn(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, rand_block(), $urandom);

    // Minimum-latency stream of four dcache reads.
    accept_log.delete();
    for (int k = 0; k < 4; k++) begin
      rand_dc(); dc_we = 1'b0;
      txn(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, rand_block(), $urandom);
    end
    for (int k = 0; k < 3; k++) chk("accept_spacing", 32'(accept_log[k+1] - accept_log[k]), 32'd4);

    // Randomized mix of requesters and bridge delays.
    for (int k = 0; k < 8; k++) begin
      n_ic = !pend_ic && ($urandom_range(0, 1) == 1);
      n_dc = !pend_dc && ($urandom_range(0, 1) == 1);
      if (!n_ic && !n_dc && !pend_ic && !pend_dc) n_dc = 1'b1;
      if (n_ic) rand_ic();
      if (n_dc) rand_dc();
      txn(n_ic, n_dc, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0,
          rand_block(), $urandom);
    end
    if (pend_ic || pend_dc) txn(1'b0, 1'b0, 1, 1, 1'b0, 1'b0, rand_block(), $urandom);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_axi_arbiter.md
# cache_axi_arbiter

Two-requester arbiter and sequencer between the instruction cache, the data cache and the single-outstanding AXI bridge. It accepts one miss, refill or uncached access at a time from either cache, drives it onto the bridge request port, and waits for the bridge's completion. It then returns read data, or a write acknowledge, to the owning cache. It sits between `Cache` and `To_AXI` inside `core_top`.

## Interface
- `BLOCK_WIDTH`, default 128: cache line width in bits, used for block read and write data.
- `ADDR_WIDTH`, default 32: physical address width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ic_valid` / `dc_valid`  in  1 each  request pending; held stable until the matching `*_ready`.
- `ic_ready` / `dc_ready`  out  1 each  request accepted this cycle.
- `ic_we` / `dc_we`  in  1 each  1 = write, 0 = read.
- `ic_cached` / `dc_cached`  in  1 each  1 = whole-line access, 0 = single word.
- `ic_addr` / `dc_addr`  in  ADDR_WIDTH each  physical address.
- `ic_wblock` / `dc_wblock`  in  BLOCK_WIDTH each  line write data.
- `ic_wword` / `dc_wword`  in  32 each  word write data.
- `ic_wstrb` / `dc_wstrb`  in  4 each  byte enables for word access.
- `ic_resp` / `dc_resp`  out  1 each  one-cycle completion pulse.
- `resp_rblock`  out  BLOCK_WIDTH  shared line read data; valid with `*_resp`.
- `resp_rword`  out  32  shared word read data; valid with `*_resp`.
- `down_valid`  out  1  request to the bridge.
- `down_ready`  in  1  bridge accepts the request.
- `down_we`, `down_cached`, `down_addr`, `down_wblock`, `down_wword`, `down_wstrb`  out  latched copies of the granted request's fields.
- `down_finish`  in  1  bridge transaction complete (one-cycle pulse).
- `down_rblock`  in  BLOCK_WIDTH  bridge line read data.
- `down_rword`  in  32  bridge word read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `*_valid` is high, the arbiter picks a winner and asserts that requester's `*_ready` combinationally in the same cycle.
  - At the clock edge it latches the winner's fields plus an `owner` bit, then goes to ISSUE.
- **ISSUE**
  - `down_valid`=1 with the latched fields.
  - On `down_valid && down_ready` → WAIT.
  - `down_finish` arriving in this state is ignored.
- **WAIT**
  - `down_valid`=0.
  - On `down_finish`, capture `down_rblock` and `down_rword` into the response registers → RESP.
- **RESP**
  - Pulse the owner's `*_resp` for exactly one cycle, with the captured data held on `resp_rblock` / `resp_rword`.
  - Go to IDLE.
  - `*_ready` is never asserted in RESP.
- Write transactions also pass through WAIT and RESP. For writes, `resp_*` data is don't-care.
- Only one transaction is outstanding at a time.
- `*_ready` is 0 in every state except IDLE.
- The response data registers hold their value until the next capture.
- A requester that drops `*_valid` before being granted is a protocol violation; behaviour in that case is undefined.

## Timing
- Reset drives all of the following to 0: every output, the response data registers and `owner`. The round-robin pointer resets to favour the dcache. The FSM resets to IDLE.
- Reset asserted mid-transaction returns the FSM to IDLE immediately, and no `*_resp` is issued. The bridge must be reset together with this block.
- Minimum latency from request to response, with `down_ready` and `down_finish` at their earliest:
  - cycle 0: `*_valid` and `*_ready` (accept).
  - cycle 1: ISSUE with `down_ready`=1.
  - cycle 2: WAIT with `down_finish`=1.
  - cycle 3: `*_resp`.
  - This gives 3 cycles from accept to response and 4 cycles between back-to-back accepts.
- While `down_ready` stays low, ISSUE holds `down_*` stable indefinitely.

## Configuration
- Macro: `CACHE_ARB_ROUND_ROBIN_EN`.
- **Defined:** round-robin arbitration.
  - After each grant, the pointer moves to favour the other requester.
  - On simultaneous requests, the favoured requester wins.
  - A lone requester always wins regardless of the pointer.
- **Undefined:** fixed priority; the dcache always wins on simultaneous requests. The pointer logic is not compiled.

## Test plan
- **Single icache cached read.** `ic_valid`=1, `ic_addr`=0x1C000000, `ic_cached`=1; bridge sets `down_ready`=1 at once and `down_finish` 5 cycles later with `down_rblock`=0x0123…CDEF.
  - Required: `ic_ready` in cycle 0, `down_addr`=0x1C000000 with `down_we`=0, and `ic_resp` one cycle after finish with `resp_rblock` matching.
- **Dcache uncached word write.** `dc_we`=1, `dc_cached`=0, `dc_addr`=0xBFAF8000, `dc_wword`=0xDEADBEEF, `dc_wstrb`=0xF.
  - Required: the `down_*` fields mirror these values, and `dc_resp` pulses once with `ic_resp`=0 throughout.
- **Simultaneous requests, repeated 3 times.**
  - Macro undefined: the grant order is dc, dc, dc.
  - Macro defined: the grant order is dc, ic, dc, followed by a final ic grant once dc has gone idle.
- **Bridge backpressure.** Hold `down_ready`=0 for 10 cycles.
  - Required: `down_valid`=1 and the fields stay stable throughout, `*_ready` stays 0 for a newly arriving request, and a `down_finish` pulsed in ISSUE is ignored.
- **Reset during WAIT.** Assert `rst` 2 cycles after the bridge accepts.
  - Required: all outputs are 0 immediately and no `*_resp` is issued. After release, a new `ic_valid` is accepted in the first cycle.
- **Minimum-latency stream.** 4 back-to-back dcache reads with the bridge responding at its earliest.
  - Required: accepts exactly 4 cycles apart and each `dc_resp` exactly 3 cycles after its accept.
